// File: rtl/scan_pkg.sv
// Shared types and sizes for the row scan sequencer and its helpers.
package scan_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} scan_state_t;
  localparam int ROW_IDX_W = 3;
  localparam int ROWS      = 8;
endpackage

// File: rtl/dwell_counter.sv
// Free-running dwell counter with synchronous clear; done flags count == limit.
module dwell_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] limit,
  output logic             done
);
  logic [DIV_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Equality compare only: a limit of all-ones is reached before any overflow.
  assign done = (count_reg == limit);
endmodule

// File: rtl/row_scan_sequencer.sv
// Timed row scan controller driving a 3-to-8 decoder's select/enable.
// Optional macro ROW_MASK_EN adds a per-row skip mask input.
module row_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_W-1:0]     div,
  input  logic [ROW_IDX_W-1:0] last,
`ifdef ROW_MASK_EN
  input  logic [ROWS-1:0]      row_mask,
`endif
  output logic [ROW_IDX_W-1:0] sel_o,
  output logic                 en_o,
  output logic                 wrap_o,
  output logic                 busy_o
);
  scan_state_t          state_reg, state_next;
  logic [ROW_IDX_W-1:0] sel_reg, sel_next;
  logic [ROW_IDX_W-1:0] last_q, last_next;
  logic [DIV_W-1:0]     div_q, div_next;
  logic                 stop_pend_reg, stop_pend_next;
  logic                 en_reg, en_next;
  logic                 wrap_reg, wrap_next;
  logic                 busy_reg, busy_next;
  logic                 row_skip;
  logic                 cnt_clr, cnt_en, cnt_done;

  dwell_counter #(.DIV_W(DIV_W)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (div_q),
    .done  (cnt_done)
  );

  // Counter runs only while driving and restarts from 0 for every row.
  assign cnt_en  = (state_reg == DRIVE);
  assign cnt_clr = (state_reg != DRIVE) || cnt_done;

`ifdef ROW_MASK_EN
  assign row_skip = row_mask[sel_next];
`else
  assign row_skip = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    last_next      = last_q;
    div_next       = div_q;
    stop_pend_next = stop_pend_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = DRIVE;
          sel_next       = '0;
          last_next      = last;
          div_next       = div;
          stop_pend_next = 1'b0;
        end
      end
      DRIVE: begin
        if (stop) stop_pend_next = 1'b1;
        if (cnt_done) state_next = BLANK;
      end
      BLANK: begin
        if (stop) stop_pend_next = 1'b1;
        if (sel_reg != last_q) begin
          sel_next   = sel_reg + 1'b1;
          div_next   = div;
          state_next = DRIVE;
        end else begin
          sel_next = '0;
          if (stop_pend_reg || stop) begin
            state_next     = IDLE;
            stop_pend_next = 1'b0;
          end else begin
            state_next = DRIVE;
            last_next  = last;
            div_next   = div;
          end
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
      end
    endcase

    // Outputs are precomputed from the next state so they leave a flop directly.
    busy_next = (state_next != IDLE);
    en_next   = (state_next == DRIVE) && !row_skip;
    wrap_next = (state_next == BLANK) && (sel_next == last_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      last_q        <= '0;
      div_q         <= '0;
      stop_pend_reg <= 1'b0;
      en_reg        <= 1'b0;
      wrap_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      last_q        <= last_next;
      div_q         <= div_next;
      stop_pend_reg <= stop_pend_next;
      en_reg        <= en_next;
      wrap_reg      <= wrap_next;
      busy_reg      <= busy_next;
    end
  end

  assign sel_o  = sel_reg;
  assign en_o   = en_reg;
  assign wrap_o = wrap_reg;
  assign busy_o = busy_reg;
endmodule

// File: doc/row_scan_sequencer.md
# row_scan_sequencer

Timed scan controller that drives the select/enable inputs of the 3-to-8 row decoder in the display/keypad scan path. On `start` it steps a 3-bit row index from 0 to a programmable last row. Each row is held enabled for a programmable dwell time, then a one-cycle blanking gap follows. The scan repeats frame after frame until `stop`. Its outputs connect directly to the decoder's `in`/`en`; `en_o` low puts the decoder in its disabled (all-ones) state.

## Interface
- `DIV_W`, default 16: width of the dwell-count input and the internal counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin scanning; accepted only in IDLE.
- `stop`  in  1  request halt at end of the current frame; accepted only while running.
- `div`  in  DIV_W  dwell count; each row is driven for `div`+1 cycles.
- `last`  in  3  highest row index scanned; frame covers rows 0..`last`.
- `row_mask`  in  8  per-row skip mask; present only with `ROW_MASK_EN`.
- `sel_o`  out  3  row index to the decoder `in`.
- `en_o`  out  1  decoder enable; 1 = drive row `sel_o`.
- `wrap_o`  out  1  one-cycle pulse marking the end of a frame.
- `busy_o`  out  1  1 whenever the state is not IDLE.

## Operation
- States are IDLE, DRIVE and BLANK.
- **Reset value of every output:** `sel_o`=0, `en_o`=0, `wrap_o`=0, `busy_o`=0. Internal state is IDLE, stop-pending is 0 and the dwell counter is 0.
- **IDLE:**
  - `start`=1 → DRIVE with `sel_o`=0 and counter 0. `last` is captured into `last_q` and `div` into `div_q`.
  - `stop` is ignored. If `start` and `stop` are asserted together, start wins and no stop is latched.
- **DRIVE:**
  - `en_o`=1 and the counter increments each cycle.
  - When counter == `div_q`: go to BLANK and clear the counter.
- **BLANK:** lasts exactly one cycle with `en_o`=0.
  - If `sel_o` != `last_q`: `sel_o`+1, then DRIVE. `div` is recaptured at each row start.
  - If `sel_o` == `last_q`: `wrap_o`=1 in this cycle. Then:
    - stop-pending → IDLE with `sel_o`=0 and stop-pending cleared;
    - otherwise → `sel_o`=0 and DRIVE, with `last` and `div` recaptured.
- `stop` while running sets stop-pending, which stays set until the frame ends. The current frame always completes.
- `start` while running is ignored.
- `last` is sampled only at frame start; `div` only at row start. Mid-row changes to either have no effect on the current row.
- `last`=0 is legal: single-row scan with a `wrap_o` pulse every row.
- Index arithmetic is 3-bit. 7→0 wraps only through the `last_q` compare, never by overflow.
- The counter is DIV_W bits and compares for equality only. `div`=all-ones gives a dwell of 2^DIV_W cycles.
- **Reset mid-operation:** takes effect at the next edge and overrides all inputs. Outputs return to reset values; no `wrap_o` is issued.

## Timing
- `start` sampled at edge N → `busy_o`=1, `en_o`=1, `sel_o`=0 from N+1.
- Row period is `div`+2 cycles: `div`+1 DRIVE plus 1 BLANK.
- Frame period is (`last`+1)·(`div`+2) cycles.
- `sel_o` changes only on the edge leaving BLANK, so it is stable for the whole time `en_o`=1. `en_o` is 0 for one cycle around every index change.
- All outputs are registered; there is no combinational input→output path.
- `wrap_o` coincides with the last BLANK of a frame.
- `busy_o` falls on the edge after the final BLANK.

## Configuration
- Macro: `ROW_MASK_EN`.
- **Defined:**
  - The `row_mask` port exists.
  - A row whose mask bit is 1 keeps its full time slot: sequencing and counting are unchanged, but `en_o` is held at 0 throughout its DRIVE.
  - Frame period is therefore unchanged by the mask.
  - The mask is sampled each cycle.
- **Undefined:** the port is absent and every row in 0..`last` is driven.

## Structure
- **Package `scan_pkg`:**
  - `typedef enum logic [1:0] {IDLE, DRIVE, BLANK} scan_state_t`;
  - localparams `ROW_IDX_W`=3 and `ROWS`=8.
- **Sub-module `dwell_counter`:**
  - parameter DIV_W;
  - inputs `clk`, `rst`, `clr`, `en`, `limit`;
  - output `done` (counter == `limit`).
  - Instantiated once; the FSM in `row_scan_sequencer` owns everything else.

## Test plan
- Reset, then `start` with `div`=2, `last`=3 → `sel_o` 0,1,2,3 with `en_o` high 3 cycles per row and 1-cycle gaps. `wrap_o` fires every 16 cycles.
- Assert `stop` during row 1 of a running frame → rows 2 and 3 still driven. `wrap_o` fires, then IDLE with `busy_o`=0 and `sel_o`=0.
- `last`=0, `div`=0 → `en_o` alternates 1,0 with `sel_o`=0 constant and `wrap_o` on every second cycle. Changing `last` to 7 mid-frame takes effect only after the next `wrap_o`.
- Simultaneous `start`+`stop` in IDLE → scan runs continuously with no stop latched. A `start` pulse while busy is ignored: no index reset.
- Assert `rst` for one cycle mid-DRIVE of row 5 → all outputs 0 on the next cycle with no `wrap_o`. A subsequent `start` restarts at row 0.
- With `ROW_MASK_EN` and `row_mask`=8'b0000_0100, `last`=3, `div`=1 → row 2 slot shows `en_o`=0 for its full DRIVE time. Frame period stays 12 cycles.
